bcd_to_binary: RTL
==================

# bcd_to_binary

Sequential converter from 5-digit packed BCD to a 16-bit unsigned binary value. It is the inverse of the calculator's binary-to-BCD display path. Keypad/entry logic accumulates operands as BCD digits, and this block turns them into binary operands for the ALU. It uses reverse double-dabble with one iteration per clock, under a start/done handshake.

## Interface
- No parameters; widths fixed (20-bit BCD in, 16-bit binary out).
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request conversion of bcdin; sampled only when idle
- bcdin  input  20  packed BCD, digit 4 = bits 19:16 ... digit 0 = bits 3:0
- binout  output  16  converted value, low 16 bits of result; held until next completion
- ovf  output  1  result exceeded 65535 (valid with done, held with binout)
- err  output  1  some input nibble > 9 (valid with done, held with binout)
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse: binout/ovf/err just updated

## Operation
- States:
  - IDLE: busy=0, waiting for start.
  - RUN: busy=1, iterating.
- IDLE, start=1 at an edge:
  - Capture bcdin into a 20-bit working register W.
  - Clear the 17-bit accumulator A and the 5-bit iteration counter.
  - Check every nibble.
  - If any nibble > 9: stay IDLE and, at the same edge, set err=1, binout=0, ovf=0, done=1. Otherwise go to RUN.
- RUN, each edge performs one iteration:
  - Shift {W, A} right by 1 as a 37-bit value; W[0] enters A[16].
  - Then, in each 4-bit digit of the shifted W, subtract 3 from every digit whose value is >= 8.
  - Increment the counter.
- After 17 iterations, A holds the binary value 0..99999. At that 17th edge:
  - binout = A[15:0]
  - ovf = A[16]
  - err = 0
  - done = 1
  - state = IDLE
- Arithmetic: unsigned only. Digit correction is per nibble, with no borrow between nibbles.
- start while busy=1 is ignored; bcdin changes during RUN have no effect (W is captured).
- start in the cycle done is high is accepted, because the state is already IDLE.
- done is high for exactly one cycle per accepted start. It is deasserted at the next edge unless that edge completes another conversion.

## Timing
- Reset (rst=1 at an edge, any state, including mid-RUN):
  - State = IDLE.
  - binout=0, ovf=0, err=0, busy=0, done=0.
  - W, A and the counter are cleared.
  - Any conversion in progress is discarded with no done pulse.
- rst has priority over start in the same cycle.
- Valid input: start sampled at edge N → busy=1 after edge N → result and done=1 after edge N+17 → busy=0 after edge N+17. Latency is 17 cycles; back-to-back throughput is one conversion per 17 cycles.
- Invalid input: start at edge N → done=1, err=1 after edge N; busy never rises.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset mid-conversion: start with bcdin=20'h12345, assert rst at edge N+5 → all outputs 0 after that edge, no done pulse follows, block accepts a new start afterward.
- Basic conversion: bcdin=20'h12345, pulse start → done exactly 17 cycles later with binout=16'h3039, ovf=0, err=0; busy high for those 17 cycles.
- Boundaries:
  - bcdin=20'h00000 → binout=0.
  - bcdin=20'h65535 → binout=16'hFFFF, ovf=0.
  - bcdin=20'h65536 → binout=16'h0000, ovf=1.
  - bcdin=20'h99999 → binout=16'h869F, ovf=1.
- Invalid digit: bcdin=20'h1A000 → done and err=1 one cycle after start, binout=0, busy stays 0.
- Handshake:
  - Start pulses during RUN are ignored, and bcdin changes during RUN do not alter the result.
  - Start asserted in the done cycle (bcdin=20'h00010) → second done 17 cycles later with binout=16'h000A.
- Random sweep: 1000 random valid 5-digit BCD inputs vs reference model (decimal value, low 16 bits, ovf = value > 65535); exactly one done per start.

Source files
------------

// File: rtl/bcd_to_binary.sv
// 5-digit packed BCD to 16-bit binary converter.
// Reverse double-dabble, one shift/correct iteration per clock.
module bcd_to_binary (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] bcdin,
    output logic [15:0] binout,
    output logic        ovf,
    output logic        err,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [19:0] w, w_n, w_sh, w_fix;
    logic [16:0] a, a_n, a_sh;
    logic [4:0]  cnt, cnt_n;
    logic [15:0] bin_n;
    logic        ovf_n, err_n, done_n;
    logic        bad;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bcdin[4*i +: 4] > 4'd9) bad = 1'b1;
        end
    end

    // one iteration: shift {w,a} right, then -3 on any digit >= 8
    always_comb begin
        w_sh  = {1'b0, w[19:1]};
        a_sh  = {w[0], a[16:1]};
        w_fix = w_sh;
        for (int i = 0; i < 5; i++) begin
            if (w_sh[4*i +: 4] >= 4'd8)
                w_fix[4*i +: 4] = w_sh[4*i +: 4] - 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            w      <= '0;
            a      <= '0;
            cnt    <= '0;
            binout <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            w      <= w_n;
            a      <= a_n;
            cnt    <= cnt_n;
            binout <= bin_n;
            ovf    <= ovf_n;
            err    <= err_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        w_n     = w;
        a_n     = a;
        cnt_n   = cnt;
        bin_n   = binout;
        ovf_n   = ovf;
        err_n   = err;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    w_n   = bcdin;
                    a_n   = '0;
                    cnt_n = '0;
                    if (bad) begin
                        err_n  = 1'b1;
                        bin_n  = '0;
                        ovf_n  = 1'b0;
                        done_n = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                w_n   = w_fix;
                a_n   = a_sh;
                cnt_n = cnt + 5'd1;
                if (cnt == 5'd16) begin
                    bin_n   = a_sh[15:0];
                    ovf_n   = a_sh[16];
                    err_n   = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

endmodule
